add_sub_fu: RTL and testbench
=============================

ADD_SUB_FU -- requirements
Module: add_sub_fu

Interface
REQ-001 SHALL provide: CLK  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL provide: CLR  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide: despacho  input  1  dispatch request from reservation station, held until confirma sampled.
REQ-004 SHALL provide: Valor1, Valor2  input  16 each  operands, valid while despacho=1.
REQ-005 SHALL provide: OP  input  3  opcode; 3'b001 = SUB, all other codes = ADD.
REQ-006 SHALL provide: ID_in  input  3  tag of issuing station; 3'b000 means "no tag".
REQ-007 SHALL provide: confirma  output  1  one-cycle acceptance pulse back to the station.
REQ-008 SHALL provide: busy  output  1  high when a new dispatch cannot be accepted.
REQ-009 SHALL provide: cdb_req  output  1  request for the common data bus.
REQ-010 SHALL provide: cdb_grant  input  1  bus grant from arbiter.
REQ-011 SHALL provide: CDB  output  19  [18:16] tag, [15:0] result; 19'b0 when idle.

Function
REQ-012 SHALL contain one execute stage (states IDLE, EXEC, HOLD) and a 2-entry result FIFO of {tag, result}.
REQ-013 Accept: at a rising edge with despacho=1, stage in IDLE, confirma=0: latch Valor1, Valor2, OP, ID_in; enter EXEC; drive confirma=1 for exactly the next cycle.
REQ-014 SHALL ignore despacho in the cycle confirma=1 (station still holds it high); no double accept.
REQ-015 EXEC SHALL last exactly 2 cycles; result = Valor1+Valor2 or Valor1-Valor2, modulo 2^16, carry/borrow discarded.
REQ-016 End of EXEC: FIFO not full -> push, return to IDLE; FIFO full -> HOLD until a pop frees an entry, push in that same cycle.
REQ-017 Tag 3'b000 results SHALL be computed but never pushed (dropped; no CDB cycle).
REQ-018 busy SHALL equal (state != IDLE) OR confirma.
REQ-019 cdb_req SHALL be high whenever the FIFO is non-empty.
REQ-020 Edge with cdb_req=1 and cdb_grant=1: pop head; CDB carries {tag,result} for exactly the following cycle, then returns to 0.
REQ-021 cdb_grant while FIFO empty SHALL be ignored; CDB stays 0.
REQ-022 Simultaneous push and pop on a full FIFO SHALL succeed; order preserved (oldest broadcast first).
REQ-023 Total latency, accept edge to CDB valid, SHALL be 4 cycles with immediate grant and empty FIFO.

Reset
REQ-024 CLR=1 at an edge SHALL return to IDLE, empty the FIFO, discard in-flight operation, set confirma=0, cdb_req=0, CDB=0, busy=0 next cycle.
REQ-025 Dispatch while CLR=1 SHALL be ignored; CLR overrides every other event in the same cycle.

Configuration
REQ-026 Macro ADD_SUB_FU_OVF_EN defined: extra output ovf (1 bit), registered with CDB, =1 when a broadcast result had signed 16-bit overflow; FIFO entry widened by 1 bit.
REQ-027 Macro undefined: ovf port and overflow logic absent; all other behaviour identical.

Verification
REQ-028 ADD 16'h0005+16'h0003, ID 3'b010, grant held 1 -> confirma at cycle+1, CDB=19'h2_0008 (tag 010) at cycle+4, then 0.
REQ-029 SUB 16'h0000-16'h0001, ID 3'b011 -> CDB tag 011, data 16'hFFFF; with ADD_SUB_FU_OVF_EN 16'h7FFF+16'h0001 -> data 16'h8000, ovf=1.
REQ-030 grant held 0, three back-to-back dispatches -> two results buffered, third in HOLD, busy=1, fourth despacho gets no confirma; grant released -> tags broadcast in dispatch order.
REQ-031 despacho held 1 across confirma cycle -> exactly one confirma pulse, one result.
REQ-032 ID 3'b000 dispatch -> confirma pulses, cdb_req stays 0, CDB stays 0.
REQ-033 CLR asserted during EXEC with one FIFO entry pending -> next cycle cdb_req=0, CDB=0, busy=0; no stale broadcast afterwards.

Source files
------------

// File: rtl/add_sub_fu_if.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_fu_if
// Purpose  : Dispatch / result-bus bundle between a reservation station, the
//            add/sub unit and the CDB arbiter. ovf exists with ADD_SUB_FU_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface add_sub_fu_if;
    logic        despacho;
    logic [15:0] Valor1;
    logic [15:0] Valor2;
    logic [2:0]  OP;
    logic [2:0]  ID_in;
    logic        confirma;
    logic        busy;
    logic        cdb_req;
    logic        cdb_grant;
    logic [18:0] CDB;
`ifdef ADD_SUB_FU_OVF_EN
    logic        ovf;

    modport master (
        output despacho, Valor1, Valor2, OP, ID_in, cdb_grant,
        input  confirma, busy, cdb_req, CDB, ovf
    );

    modport slave (
        input  despacho, Valor1, Valor2, OP, ID_in, cdb_grant,
        output confirma, busy, cdb_req, CDB, ovf
    );
`else
    modport master (
        output despacho, Valor1, Valor2, OP, ID_in, cdb_grant,
        input  confirma, busy, cdb_req, CDB
    );

    modport slave (
        input  despacho, Valor1, Valor2, OP, ID_in, cdb_grant,
        output confirma, busy, cdb_req, CDB
    );
`endif
endinterface
`default_nettype wire

// File: rtl/add_sub_fu.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_fu
// Purpose  : 16-bit add/sub functional unit, 2-cycle execute, 2-entry CDB
//            result FIFO. Define ADD_SUB_FU_OVF_EN to add the ovf output.
// Revision : 1.0 - initial release
// ============================================================================
module add_sub_fu (
    input  wire logic        CLK,
    input  wire logic        CLR,
    add_sub_fu_if.slave      bus
);

    localparam int unsigned c_data_w = 16;
    localparam int unsigned c_tag_w  = 3;
`ifdef ADD_SUB_FU_OVF_EN
    localparam int unsigned c_entry_w = c_tag_w + c_data_w + 1;
`else
    localparam int unsigned c_entry_w = c_tag_w + c_data_w;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                              r_state_q,    w_state_d;
    logic                                r_cnt_q,      w_cnt_d;
    logic [c_data_w-1:0]                 r_a_q,        w_a_d;
    logic [c_data_w-1:0]                 r_b_q,        w_b_d;
    logic                                r_sub_q,      w_sub_d;
    logic [c_tag_w-1:0]                  r_tag_q,      w_tag_d;
    logic                                r_confirma_q, w_confirma_d;
    logic [1:0][c_entry_w-1:0]           r_fifo_q,     w_fifo_d;
    logic                                r_rd_q,       w_rd_d;
    logic                                r_wr_q,       w_wr_d;
    logic [1:0]                          r_count_q,    w_count_d;
    logic [c_tag_w+c_data_w-1:0]         r_cdb_q,      w_cdb_d;
`ifdef ADD_SUB_FU_OVF_EN
    logic                                r_ovf_q,      w_ovf_d;
    logic                                w_ovf;
`endif

    logic                                w_accept;
    logic                                w_pop;
    logic                                w_push;
    logic                                w_full;
    logic [c_data_w-1:0]                 w_res;
    logic [c_entry_w-1:0]                w_entry;

    assign w_res    = r_sub_q ? (r_a_q - r_b_q) : (r_a_q + r_b_q);
    assign w_full   = (r_count_q == 2'd2);
    assign w_pop    = (r_count_q != 2'd0) && bus.cdb_grant;
    assign w_accept = bus.despacho && (r_state_q == IDLE) && !r_confirma_q;

`ifdef ADD_SUB_FU_OVF_EN
    // Signed overflow: operands (second one inverted for SUB) agree in sign, result does not.
    assign w_ovf   = ((r_a_q[c_data_w-1] == (r_b_q[c_data_w-1] ^ r_sub_q)) &&
                      (w_res[c_data_w-1] != r_a_q[c_data_w-1]));
    assign w_entry = {w_ovf, r_tag_q, w_res};
`else
    assign w_entry = {r_tag_q, w_res};
`endif

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_a_d        = r_a_q;
        w_b_d        = r_b_q;
        w_sub_d      = r_sub_q;
        w_tag_d      = r_tag_q;
        w_confirma_d = 1'b0;
        w_fifo_d     = r_fifo_q;
        w_rd_d       = r_rd_q;
        w_wr_d       = r_wr_q;
        w_count_d    = r_count_q;
        w_cdb_d      = '0;
        w_push       = 1'b0;
`ifdef ADD_SUB_FU_OVF_EN
        w_ovf_d      = 1'b0;
`endif

        case (r_state_q)
            IDLE: begin
                if (w_accept) begin
                    w_a_d        = bus.Valor1;
                    w_b_d        = bus.Valor2;
                    w_sub_d      = (bus.OP == 3'b001);
                    w_tag_d      = bus.ID_in;
                    w_cnt_d      = 1'b0;
                    w_confirma_d = 1'b1;
                    w_state_d    = EXEC;
                end
            end
            EXEC: begin
                if (!r_cnt_q) begin
                    w_cnt_d = 1'b1;
                end else if (r_tag_q == '0) begin
                    w_state_d = IDLE;
                end else if (!w_full || w_pop) begin
                    w_push    = 1'b1;
                    w_state_d = IDLE;
                end else begin
                    w_state_d = HOLD;
                end
            end
            HOLD: begin
                if (w_pop) begin
                    w_push    = 1'b1;
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // The broadcast register holds a popped entry for exactly one cycle.
        if (w_pop) begin
            w_cdb_d = r_fifo_q[r_rd_q][c_tag_w+c_data_w-1:0];
`ifdef ADD_SUB_FU_OVF_EN
            w_ovf_d = r_fifo_q[r_rd_q][c_entry_w-1];
`endif
            w_rd_d  = ~r_rd_q;
        end
        if (w_push) begin
            w_fifo_d[r_wr_q] = w_entry;
            w_wr_d           = ~r_wr_q;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + 2'd1;
            2'b01:   w_count_d = r_count_q - 2'd1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state_q    <= IDLE;
            r_cnt_q      <= 1'b0;
            r_a_q        <= '0;
            r_b_q        <= '0;
            r_sub_q      <= 1'b0;
            r_tag_q      <= '0;
            r_confirma_q <= 1'b0;
            r_fifo_q     <= '0;
            r_rd_q       <= 1'b0;
            r_wr_q       <= 1'b0;
            r_count_q    <= 2'd0;
            r_cdb_q      <= '0;
`ifdef ADD_SUB_FU_OVF_EN
            r_ovf_q      <= 1'b0;
`endif
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_a_q        <= w_a_d;
            r_b_q        <= w_b_d;
            r_sub_q      <= w_sub_d;
            r_tag_q      <= w_tag_d;
            r_confirma_q <= w_confirma_d;
            r_fifo_q     <= w_fifo_d;
            r_rd_q       <= w_rd_d;
            r_wr_q       <= w_wr_d;
            r_count_q    <= w_count_d;
            r_cdb_q      <= w_cdb_d;
`ifdef ADD_SUB_FU_OVF_EN
            r_ovf_q      <= w_ovf_d;
`endif
        end
    end

    assign bus.confirma = r_confirma_q;
    assign bus.busy     = (r_state_q != IDLE) || r_confirma_q;
    assign bus.cdb_req  = (r_count_q != 2'd0);
    assign bus.CDB      = r_cdb_q;
`ifdef ADD_SUB_FU_OVF_EN
    assign bus.ovf      = r_ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_sub_fu.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_sub_fu
// Purpose  : Directed-vector bench for add_sub_fu with a CDB scoreboard.
//            ovf is also checked when ADD_SUB_FU_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_sub_fu;

    logic clk;
    logic clr;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_conf = 0;
    logic [19:0] exp_q[$];

    add_sub_fu_if bus();

    add_sub_fu dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected entries are {ovf, tag, data}.
    task automatic dispatch(input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] op, input logic [2:0] id,
                            input logic [19:0] exp, input int hold_extra);
        logic got;
        got          = 1'b0;
        bus.despacho = 1'b1;
        bus.Valor1   = a;
        bus.Valor2   = b;
        bus.OP       = op;
        bus.ID_in    = id;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.confirma === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("dispatch_timeout", {31'd0, got}, 32'd1);
        if (got && id != 3'd0) exp_q.push_back(exp);
        repeat (hold_extra) tick();
        bus.despacho = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.confirma === 1'b1) n_conf++;
    end

    // Monitor: every non-zero CDB cycle must match the oldest outstanding result.
    always @(negedge clk) begin
        logic [19:0] e;
        if (!clr && bus.CDB !== 19'd0) begin
            if (exp_q.size() == 0) begin
                chk("cdb_unexpected", {13'd0, bus.CDB}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("cdb_data", {13'd0, bus.CDB}, {13'd0, e[18:0]});
`ifdef ADD_SUB_FU_OVF_EN
                chk("cdb_ovf", {31'd0, bus.ovf}, {31'd0, e[19]});
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c0;
        logic seen;
        clr           = 1'b1;
        bus.despacho  = 1'b0;
        bus.Valor1    = '0;
        bus.Valor2    = '0;
        bus.OP        = '0;
        bus.ID_in     = '0;
        bus.cdb_grant = 1'b0;
        tick();
        tick();
        chk("rst_confirma", {31'd0, bus.confirma}, 32'd0);
        chk("rst_busy",     {31'd0, bus.busy},     32'd0);
        chk("rst_cdb_req",  {31'd0, bus.cdb_req},  32'd0);
        chk("rst_cdb",      {13'd0, bus.CDB},      32'd0);
        clr = 1'b0;
        tick();

        // 5 + 3, tag 2, immediate grant: exact latency profile
        bus.cdb_grant = 1'b1;
        bus.despacho  = 1'b1;
        bus.Valor1    = 16'h0005;
        bus.Valor2    = 16'h0003;
        bus.OP        = 3'b000;
        bus.ID_in     = 3'b010;
        exp_q.push_back(20'h2_0008);
        tick();
        chk("lat_confirma_c1", {31'd0, bus.confirma}, 32'd1);
        chk("lat_busy_c1",     {31'd0, bus.busy},     32'd1);
        bus.despacho = 1'b0;
        tick();
        chk("lat_confirma_c2", {31'd0, bus.confirma}, 32'd0);
        chk("lat_busy_c2",     {31'd0, bus.busy},     32'd1);
        tick();
        chk("lat_cdb_req_c3",  {31'd0, bus.cdb_req},  32'd1);
        chk("lat_busy_c3",     {31'd0, bus.busy},     32'd0);
        chk("lat_cdb_c3",      {13'd0, bus.CDB},      32'd0);
        tick();
        chk("lat_cdb_c4",      {13'd0, bus.CDB},      32'h2_0008);
        chk("lat_cdb_req_c4",  {31'd0, bus.cdb_req},  32'd0);
        tick();
        chk("lat_cdb_c5",      {13'd0, bus.CDB},      32'd0);

        // Arithmetic vectors, including wrap-around and overflow cases
        dispatch(16'h0000, 16'h0001, 3'b001, 3'd3, 20'h0_3FFFF >> 0, 0);
        dispatch(16'h7FFF, 16'h0001, 3'b000, 3'd4, {1'b1, 19'h4_8000}, 0);
        dispatch(16'h8000, 16'h0001, 3'b001, 3'd5, {1'b1, 19'h5_7FFF}, 0);
        dispatch(16'hFFFF, 16'h0001, 3'b111, 3'd6, {1'b0, 19'h6_0000}, 0);
        repeat (8) tick();

        // Tag 0: accepted but never broadcast
        c0 = n_conf;
        dispatch(16'h0001, 16'h0001, 3'b000, 3'd0, 20'd0, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.cdb_req !== 1'b0) seen = 1'b1;
        end
        chk("tag0_confirma_count", n_conf - c0, 32'd1);
        chk("tag0_cdb_req_seen",   {31'd0, seen}, 32'd0);

        // despacho held across the confirma cycle
        c0 = n_conf;
        dispatch(16'h0010, 16'h0020, 3'b010, 3'd7, {1'b0, 19'h7_0030}, 2);
        repeat (8) tick();
        chk("hold_confirma_count", n_conf - c0, 32'd1);

        // No grant: two buffered, third stuck in HOLD, fourth refused
        bus.cdb_grant = 1'b0;
        dispatch(16'h1000, 16'h0234, 3'b000, 3'd1, {1'b0, 19'h1_1234}, 0);
        dispatch(16'h00FF, 16'h000F, 3'b001, 3'd2, {1'b0, 19'h2_00F0}, 0);
        dispatch(16'hABCD, 16'h1111, 3'b000, 3'd3, {1'b0, 19'h3_BCDE}, 0);
        repeat (4) tick();
        chk("full_busy",    {31'd0, bus.busy},    32'd1);
        chk("full_cdb_req", {31'd0, bus.cdb_req}, 32'd1);
        c0 = n_conf;
        bus.despacho = 1'b1;
        bus.ID_in    = 3'd4;
        repeat (5) tick();
        bus.despacho = 1'b0;
        chk("full_no_confirma", n_conf - c0, 32'd0);
        bus.cdb_grant = 1'b1;
        repeat (10) tick();
        chk("full_drained_busy", {31'd0, bus.busy}, 32'd0);

        // Reset during EXEC with one result pending
        bus.cdb_grant = 1'b0;
        dispatch(16'h0001, 16'h0001, 3'b000, 3'd6, {1'b0, 19'h6_0002}, 0);
        dispatch(16'h0002, 16'h0002, 3'b000, 3'd7, {1'b0, 19'h7_0004}, 0);
        chk("clr_pre_cdb_req", {31'd0, bus.cdb_req}, 32'd1);
        clr          = 1'b1;
        bus.despacho = 1'b1;
        bus.ID_in    = 3'd1;
        tick();
        exp_q.delete();
        chk("clr_cdb_req",  {31'd0, bus.cdb_req},  32'd0);
        chk("clr_cdb",      {13'd0, bus.CDB},      32'd0);
        chk("clr_busy",     {31'd0, bus.busy},     32'd0);
        chk("clr_confirma", {31'd0, bus.confirma}, 32'd0);
        clr           = 1'b0;
        bus.despacho  = 1'b0;
        bus.cdb_grant = 1'b1;
        repeat (10) tick();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
